// File: rtl/pacman_pkg.sv
// Shared Pac-Man game constants: point values, level size, bonus threshold,
// score ceiling and the game-flow state encoding.
package pacman_pkg;

  localparam logic [17:0] PELLET_PTS     = 18'd10;
  localparam logic [17:0] POWER_PTS      = 18'd50;
  localparam logic [17:0] GHOST_BASE_PTS = 18'd200;
  localparam logic [7:0]  DOTS_PER_LEVEL = 8'd244;
  localparam logic [17:0] EXTRA_LIFE_AT  = 18'd10000;
  localparam logic [17:0] SCORE_MAX      = 18'd262143;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    INTER = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  function automatic logic [17:0] sat_add(input logic [17:0] a, input logic [17:0] b);
    logic [18:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, SCORE_MAX}) ? SCORE_MAX : s[17:0];
  endfunction

endpackage

// File: rtl/score_keeper.sv
// Score, lives, high score and level/intermission flow for the gameclk domain.
// All events of one cycle are folded into a single registered update.
module score_keeper
  import pacman_pkg::*;
#(
  parameter int unsigned START_LIVES         = 3,
  parameter int unsigned INTERMISSION_CYCLES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        pellet_eaten,
  input  logic        power_eaten,
  input  logic [3:0]  ghost_eaten,
  input  logic        life_lost,
  output logic [17:0] score,
  output logic [17:0] high_score,
  output logic [2:0]  lives,
  output logic [1:0]  chain_idx,
  output logic [7:0]  dots_eaten,
  output logic        level_clear,
  output logic        extra_life,
  output logic        game_over,
  output logic        playing
);

  localparam int unsigned CNT_W = $clog2(INTERMISSION_CYCLES + 1);
  localparam logic [CNT_W-1:0] INTER_LAST = CNT_W'(INTERMISSION_CYCLES - 1);

  game_state_t      state, state_n;
  logic [17:0]      score_n;
  logic [2:0]       lives_n;
  logic [1:0]       chain, chain_n;
  logic [1:0]       chain_idx_n;
  logic [7:0]       dots_n;
  logic [CNT_W-1:0] inter_cnt, inter_cnt_n;
  logic             bonus_got, bonus_got_n;
  logic             level_clear_n, extra_life_n;

  logic [1:0]       ghost_chain, ghost_idx;
  logic [17:0]      ghost_pts;
  logic [17:0]      award;
  logic [2:0]       lives_v;
  logic [8:0]       dots_v;

  // Ghost awards: power pellet restarts the chain first, then bits in ascending order.
  always_comb begin
    ghost_chain = power_eaten ? 2'd0 : chain;
    ghost_idx   = power_eaten ? 2'd0 : chain_idx;
    ghost_pts   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (ghost_eaten[i]) begin
        ghost_pts = ghost_pts + (GHOST_BASE_PTS << ghost_chain);
        ghost_idx = ghost_chain;
        if (ghost_chain != 2'd3) ghost_chain = ghost_chain + 2'd1;
      end
    end
  end

  always_comb begin
    state_n       = state;
    score_n       = score;
    lives_n       = lives;
    chain_n       = chain;
    chain_idx_n   = chain_idx;
    dots_n        = dots_eaten;
    inter_cnt_n   = inter_cnt;
    bonus_got_n   = bonus_got;
    level_clear_n = 1'b0;
    extra_life_n  = 1'b0;
    award         = (pellet_eaten ? PELLET_PTS : '0) + (power_eaten ? POWER_PTS : '0) + ghost_pts;
    lives_v       = lives;
    dots_v        = {1'b0, dots_eaten} + {8'd0, pellet_eaten} + {8'd0, power_eaten};

    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n     = PLAY;
          score_n     = '0;
          dots_n      = '0;
          chain_n     = '0;
          chain_idx_n = '0;
          lives_n     = 3'(START_LIVES);
          bonus_got_n = 1'b0;
        end
      end
      PLAY: begin
        if (!pause) begin
          score_n     = sat_add(score, award);
          chain_n     = ghost_chain;
          chain_idx_n = ghost_idx;
          dots_n      = dots_v[7:0];
          // Points land before the death so a bonus earned this cycle offsets it.
          if (!bonus_got && score_n >= EXTRA_LIFE_AT) begin
            bonus_got_n  = 1'b1;
            extra_life_n = 1'b1;
            if (lives_v != 3'd7) lives_v = lives_v + 3'd1;
          end
          if (dots_v >= {1'b0, DOTS_PER_LEVEL}) begin
            level_clear_n = 1'b1;
            chain_n       = '0;
            inter_cnt_n   = '0;
            state_n       = INTER;
          end
          if (life_lost) begin
            chain_n = '0;
            if (lives_v <= 3'd1) begin
              lives_v = '0;
              state_n = OVER;
            end else begin
              lives_v = lives_v - 3'd1;
            end
          end
          lives_n = lives_v;
        end
      end
      INTER: begin
        if (!pause) begin
          if (inter_cnt == INTER_LAST) begin
            inter_cnt_n = '0;
            dots_n      = '0;
            state_n     = PLAY;
          end else begin
            inter_cnt_n = inter_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      score       <= '0;
      high_score  <= '0;
      lives       <= '0;
      chain       <= '0;
      chain_idx   <= '0;
      dots_eaten  <= '0;
      inter_cnt   <= '0;
      bonus_got   <= 1'b0;
      level_clear <= 1'b0;
      extra_life  <= 1'b0;
    end else begin
      state       <= state_n;
      score       <= score_n;
      lives       <= lives_n;
      chain       <= chain_n;
      chain_idx   <= chain_idx_n;
      dots_eaten  <= dots_n;
      inter_cnt   <= inter_cnt_n;
      bonus_got   <= bonus_got_n;
      level_clear <= level_clear_n;
      extra_life  <= extra_life_n;
      if (score > high_score) high_score <= score;
    end
  end

  assign playing   = (state == PLAY);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with hand-computed expected values.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        pellet_eaten = 1'b0;
  logic        power_eaten = 1'b0;
  logic [3:0]  ghost_eaten = 4'd0;
  logic        life_lost = 1'b0;
  logic [17:0] score, high_score;
  logic [2:0]  lives;
  logic [1:0]  chain_idx;
  logic [7:0]  dots_eaten;
  logic        level_clear, extra_life, game_over, playing;

  int n_checks = 0;
  int n_fails  = 0;

  score_keeper #(.START_LIVES(3), .INTERMISSION_CYCLES(120)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
    .ghost_eaten(ghost_eaten), .life_lost(life_lost),
    .score(score), .high_score(high_score), .lives(lives),
    .chain_idx(chain_idx), .dots_eaten(dots_eaten),
    .level_clear(level_clear), .extra_life(extra_life),
    .game_over(game_over), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of events, then sample 1 time unit after the edge.
  task automatic cyc(input logic p, input logic pw, input logic [3:0] g, input logic ll);
    pellet_eaten = p;
    power_eaten  = pw;
    ghost_eaten  = g;
    life_lost    = ll;
    @(posedge clk);
    #1;
    pellet_eaten = 1'b0;
    power_eaten  = 1'b0;
    ghost_eaten  = 4'd0;
    life_lost    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_xl;
    repeat (3) @(posedge clk);
    #1;
    check("rst_score", int'(score), 0);
    check("rst_high", int'(high_score), 0);
    check("rst_lives", int'(lives), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_dots", int'(dots_eaten), 0);
    rst = 1'b1;

    start = 1'b1;
    cyc(0, 0, 4'd0, 0);
    start = 1'b0;
    check("start_playing", int'(playing), 1);
    check("start_lives", int'(lives), 3);
    check("start_score", int'(score), 0);

    for (int i = 1; i <= 3; i++) begin
      cyc(1, 0, 4'd0, 0);
      check("pellet_score", int'(score), 10 * i);
    end
    cyc(0, 1, 4'd0, 0);
    check("power_score", int'(score), 80);
    check("dots_4", int'(dots_eaten), 4);

    cyc(0, 1, 4'd0, 0);
    check("power2_score", int'(score), 130);
    check("power2_chain", int'(chain_idx), 0);
    cyc(0, 0, 4'b0011, 0);
    check("g0011_score", int'(score), 730);
    check("g0011_chain", int'(chain_idx), 1);
    cyc(0, 0, 4'b1100, 0);
    check("g1100_score", int'(score), 3130);
    check("g1100_chain", int'(chain_idx), 3);
    cyc(0, 0, 4'b0001, 0);
    check("g0001_score", int'(score), 4730);
    check("g0001_chain", int'(chain_idx), 3);

    pause = 1'b1;
    cyc(1, 0, 4'd0, 0);
    pause = 1'b0;
    check("pause_score", int'(score), 4730);
    check("pause_dots", int'(dots_eaten), 5);

    repeat (3) cyc(0, 0, 4'b0001, 0);
    repeat (46) cyc(1, 0, 4'd0, 0);
    check("pre_bonus_score", int'(score), 9990);
    check("pre_bonus_lives", int'(lives), 3);
    check("pre_bonus_xl", int'(extra_life), 0);
    cyc(1, 0, 4'd0, 0);
    check("bonus_score", int'(score), 10000);
    check("bonus_lives", int'(lives), 4);
    check("bonus_xl", int'(extra_life), 1);
    check("bonus_dots", int'(dots_eaten), 52);
    cyc(0, 0, 4'd0, 0);
    check("bonus_xl_drop", int'(extra_life), 0);

    seen_xl = 0;
    for (int i = 0; i < 191; i++) begin
      cyc(1, 0, 4'd0, 0);
      if (extra_life) seen_xl = 1;
    end
    check("no_second_bonus", seen_xl, 0);
    check("dots_243", int'(dots_eaten), 243);
    check("lc_before", int'(level_clear), 0);
    cyc(1, 0, 4'd0, 0);
    check("lc_pulse", int'(level_clear), 1);
    check("lc_dots", int'(dots_eaten), 244);
    check("lc_score", int'(score), 11920);
    check("lc_playing", int'(playing), 0);
    repeat (119) cyc(1, 0, 4'd0, 0);
    check("inter_119_playing", int'(playing), 0);
    check("inter_score", int'(score), 11920);
    check("inter_lc_drop", int'(level_clear), 0);
    cyc(1, 0, 4'd0, 0);
    check("inter_end_playing", int'(playing), 1);
    check("inter_end_dots", int'(dots_eaten), 0);
    check("inter_end_score", int'(score), 11920);
    cyc(1, 0, 4'd0, 0);
    check("lvl2_score", int'(score), 11930);
    check("lvl2_dots", int'(dots_eaten), 1);

    cyc(1, 0, 4'd0, 1);
    check("ll_pellet_score", int'(score), 11940);
    check("ll_lives", int'(lives), 3);
    cyc(0, 0, 4'd0, 1);
    cyc(0, 0, 4'd0, 1);
    check("ll_lives_1", int'(lives), 1);
    check("ll_not_over", int'(game_over), 0);
    cyc(0, 0, 4'd0, 1);
    check("over_lives", int'(lives), 0);
    check("over_flag", int'(game_over), 1);
    check("over_playing", int'(playing), 0);
    cyc(1, 0, 4'd0, 0);
    check("over_score_hold", int'(score), 11940);
    check("over_high", int'(high_score), 11940);

    start = 1'b1;
    cyc(0, 0, 4'd0, 0);
    start = 1'b0;
    check("restart_playing", int'(playing), 1);
    check("restart_score", int'(score), 0);
    check("restart_lives", int'(lives), 3);
    check("restart_high", int'(high_score), 11940);

    for (int i = 0; i < 86; i++) begin
      cyc(0, 1, 4'b1111, (i == 3) ? 1'b1 : 1'b0);
      if (i == 3) begin
        check("offset_score", int'(score), 12200);
        check("offset_lives", int'(lives), 3);
        check("offset_xl", int'(extra_life), 1);
      end
    end
    check("sat_score", int'(score), 262143);
    check("sat_high_lag", int'(high_score), 259250);
    check("sat_chain", int'(chain_idx), 3);
    check("sat_dots", int'(dots_eaten), 86);
    cyc(0, 1, 4'b1111, 0);
    check("sat_hold", int'(score), 262143);
    check("sat_high", int'(high_score), 262143);

    repeat (157) cyc(1, 0, 4'd0, 0);
    check("lvl_clear2", int'(level_clear), 1);
    repeat (5) cyc(0, 0, 4'd0, 0);
    check("inter2_playing", int'(playing), 0);
    rst = 1'b0;
    #2;
    check("arst_playing", int'(playing), 0);
    check("arst_over", int'(game_over), 0);
    check("arst_score", int'(score), 0);
    check("arst_high", int'(high_score), 0);
    check("arst_lives", int'(lives), 0);
    check("arst_dots", int'(dots_eaten), 0);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
